// File: rtl/cpu_defs.sv
// Shared definitions for the processor and its instruction-memory loader.
package cpu_defs;

    // Instruction word: func[7:6], rdst[5:3], rsrc[2:0]
    localparam int INSTR_W  = 8;
    localparam int FUNC_MSB = 7;
    localparam int FUNC_LSB = 6;
    localparam int RDST_MSB = 5;
    localparam int RDST_LSB = 3;
    localparam int RSRC_MSB = 2;
    localparam int RSRC_LSB = 0;

    // Instruction memory geometry
    localparam int DEPTH  = 32;
    localparam int ADDR_W = $clog2(DEPTH);

    // Loader FSM encodings
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CHECK   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ERROR   = 3'd4
    } ld_state_e;

endpackage

// File: rtl/imem_loader.sv
// Streams a program into instruction memory over a valid/ready byte stream,
// framed by a word count and closed by an XOR checksum byte. Holds the CPU in
// reset until a load completes with a matching checksum.
module imem_loader #(
    parameter int DEPTH   = cpu_defs::DEPTH,
    parameter int ADDR_W  = cpu_defs::ADDR_W,
    parameter int INSTR_W = cpu_defs::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W:0]    len,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic               err
);
    import cpu_defs::*;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    ld_state_e          state, state_nxt;
    logic [ADDR_W:0]    len_q;
    logic [ADDR_W:0]    count;
    logic [ADDR_W:0]    cnt_inc;
    logic [INSTR_W-1:0] acc;
    logic               accept;
    logic               start_take;
    logic               len_ok;

    assign accept     = in_valid & in_ready;
    assign cnt_inc    = count + ONE_L;
    // start only matters when no load is in flight
    assign start_take = start && (state == ST_IDLE || state == ST_ERROR);
    assign len_ok     = (len != '0) && (len <= DEPTH_L);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ERROR: begin
                if (start) state_nxt = len_ok ? ST_LOAD : ST_ERROR;
            end
            ST_LOAD: begin
                if (accept && cnt_inc == len_q) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (accept) state_nxt = (in_data == acc) ? ST_RELEASE : ST_ERROR;
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready = (state == ST_LOAD) || (state == ST_CHECK);
        busy     = (state == ST_LOAD) || (state == ST_CHECK);
        done     = (state == ST_RELEASE);
        err      = (state == ST_ERROR);
    end

    // Word counter, checksum accumulator, registered write port, CPU reset hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= '0;
            count     <= '0;
            acc       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b1;
        end else begin
            mem_we <= 1'b0;
            if (start_take) begin
                len_q     <= len;
                count     <= '0;
                acc       <= '0;
                cpu_reset <= 1'b1;
            end
            // Accepted program bytes are written one cycle later; the count
            // never exceeds len, so the address cannot wrap.
            if (state == ST_LOAD && accept) begin
                acc       <= acc ^ in_data;
                mem_we    <= 1'b1;
                mem_addr  <= count[ADDR_W-1:0];
                mem_wdata <= in_data;
                count     <= cnt_inc;
            end
            // CPU comes out of reset on the edge leaving RELEASE and stays out
            // until the next start.
            if (state == ST_RELEASE) cpu_reset <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios, hand-written
// reset/collision sequences, and randomized loads against a simple model.
module tb_imem_loader;
    import cpu_defs::*;

    localparam int LW = ADDR_W + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   len;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (done)   done_cnt++;
    end

    typedef struct {
        int         len;
        int         gap_mode;      // 0 none, 1 fixed 1,0,0,1,0,1 pattern, 2 random
        bit         fixed_data;    // use 0x41,0x8A,0xC5
        bit         fixed_ck;
        logic [7:0] ck;
        bit         corrupt;
        bit         collide;       // start pulse during LOAD
        bit         valid_on_start;
        int         exp_writes;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    logic [7:0] pbuf [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(int l, int gm, bit fd, bit fc, logic [7:0] c, bit cor,
                                bit col, bit vos, int ew, bit ed, bit ee);
        vec_t v;
        v.len = l; v.gap_mode = gm; v.fixed_data = fd; v.fixed_ck = fc; v.ck = c;
        v.corrupt = cor; v.collide = col; v.valid_on_start = vos;
        v.exp_writes = ew; v.exp_done = ed; v.exp_err = ee;
        return v;
    endfunction

    // Drive one complete load attempt and check its externally visible effects.
    task automatic run_load(input vec_t v);
        int         w0, d0, ng;
        logic [7:0] x, ck;
        w0 = we_cnt;
        d0 = done_cnt;
        if (v.fixed_data) begin
            pbuf[0] = 8'h41; pbuf[1] = 8'h8A; pbuf[2] = 8'hC5;
        end else begin
            for (int i = 0; i < 32; i++) pbuf[i] = 8'($urandom);
        end
        x = 8'h00;
        if (v.len >= 1 && v.len <= 32)
            for (int i = 0; i < v.len; i++) x ^= pbuf[i];
        if (v.fixed_ck)     ck = v.ck;
        else if (v.corrupt) ck = x ^ 8'($urandom_range(1, 255));
        else                ck = x;

        start    = 1'b1;
        len      = LW'(v.len);
        in_valid = v.valid_on_start;
        in_data  = 8'hEE;
        #3 chk("in_ready_on_start", in_ready, 0);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;

        if (v.exp_writes == 0) begin
            chk("badlen_err", err, 1);
            chk("badlen_busy", busy, 0);
            chk("badlen_cpu_reset", cpu_reset, 1);
            in_valid = 1'b1;
            in_data  = 8'h55;
            tick();
            chk("badlen_in_ready", in_ready, 0);
            tick();
            chk("badlen_no_we", mem_we, 0);
            chk("badlen_err_sticky", err, 1);
            in_valid = 1'b0;
        end else begin
            chk("load_busy", busy, 1);
            chk("load_err_clear", err, 0);
            chk("load_cpu_reset", cpu_reset, 1);
            chk("load_in_ready", in_ready, 1);
            chk("start_byte_not_written", mem_we, 0);
            for (int i = 0; i < v.len; i++) begin
                if (v.gap_mode == 1)      ng = (i == 1) ? 2 : (i == 2) ? 1 : 0;
                else if (v.gap_mode == 2) ng = int'($urandom_range(0, 2));
                else                      ng = 0;
                repeat (ng) begin
                    in_valid = 1'b0;
                    tick();
                    chk("gap_no_we", mem_we, 0);
                end
                in_valid = 1'b1;
                in_data  = pbuf[i];
                if (v.collide && i == 1) begin
                    start = 1'b1;
                    len   = LW'(1);
                end
                tick();
                start = 1'b0;
                chk("wr_we", mem_we, 1);
                chk("wr_addr", mem_addr, i);
                chk("wr_data", mem_wdata, pbuf[i]);
            end
            in_valid = 1'b1;
            in_data  = ck;
            tick();
            in_valid = 1'b0;
            chk("ck_not_written", mem_we, 0);
            chk("post_ck_busy", busy, 0);
            if (v.exp_done) begin
                chk("release_done", done, 1);
                chk("release_cpu_reset_held", cpu_reset, 1);
                tick();
                chk("idle_done_low", done, 0);
                chk("idle_cpu_reset_low", cpu_reset, 0);
                chk("idle_err", err, 0);
            end else begin
                chk("ckerr_err", err, 1);
                chk("ckerr_done", done, 0);
                chk("ckerr_cpu_reset", cpu_reset, 1);
                tick();
                chk("ckerr_err_sticky", err, 1);
                chk("ckerr_cpu_reset_sticky", cpu_reset, 1);
            end
        end
        chk("write_count", we_cnt - w0, v.exp_writes);
        chk("done_count", done_cnt - d0, v.exp_done);
    endtask

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_data  = '0;
        in_valid = 1'b0;

        tbl[0] = mk(3,  0, 1, 1, 8'h0E, 0, 0, 0, 3,  1, 0);  // basic load
        tbl[1] = mk(3,  0, 1, 1, 8'h0F, 0, 0, 0, 3,  0, 1);  // bad checksum
        tbl[2] = mk(0,  0, 0, 0, 8'h00, 0, 0, 0, 0,  0, 1);  // len 0
        tbl[3] = mk(33, 0, 0, 0, 8'h00, 0, 0, 0, 0,  0, 1);  // len too big
        tbl[4] = mk(32, 0, 0, 0, 8'h00, 0, 0, 0, 32, 1, 0);  // full depth
        tbl[5] = mk(3,  1, 0, 0, 8'h00, 0, 0, 0, 3,  1, 0);  // backpressure gaps
        tbl[6] = mk(4,  0, 0, 0, 8'h00, 0, 1, 0, 4,  1, 0);  // start during LOAD
        tbl[7] = mk(2,  0, 0, 0, 8'h00, 0, 0, 1, 2,  1, 0);  // start + in_valid in IDLE

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        tick();

        for (int t = 0; t < 8; t++) run_load(tbl[t]);

        // Reset in the middle of a len=4 load
        begin
            int d0;
            d0 = done_cnt;
            start = 1'b1;
            len   = LW'(4);
            tick();
            start    = 1'b0;
            in_valid = 1'b1;
            in_data  = 8'h12;
            tick();
            in_data  = 8'h34;
            tick();
            chk("midrst_pre_we", mem_we, 1);
            reset = 1'b1;
            #1;
            chk("midrst_we", mem_we, 0);
            chk("midrst_cpu_reset", cpu_reset, 1);
            chk("midrst_busy", busy, 0);
            chk("midrst_in_ready", in_ready, 0);
            chk("midrst_done", done, 0);
            chk("midrst_err", err, 0);
            in_valid = 1'b0;
            @(posedge clk);
            #2 reset = 1'b0;
            tick();
            chk("midrst_no_done", done_cnt - d0, 0);
            chk("midrst_idle_busy", busy, 0);
        end
        run_load(mk(4, 0, 0, 0, 8'h00, 0, 0, 0, 4, 1, 0));

        // Randomized loads: model expects len writes and done iff checksum intact
        for (int r = 0; r < 15; r++) begin
            int  l;
            bit  cor;
            l   = int'($urandom_range(1, 32));
            cor = ($urandom_range(0, 3) == 0);
            run_load(mk(l, 2, 0, 0, 8'h00, cor, (l >= 2) && ($urandom_range(0, 3) == 0),
                        $urandom_range(0, 1) == 1, l, !cor, cor));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
